pc_redirect_unit: RTL

Fetch-side program-counter owner and pipeline flush controller: the receiving end of the execute-stage branch/jump resolution. It holds the PC, drives the instruction-memory address, and captures the F/D PC. On a taken redirect (jump, jal, jr, taken bne/blt, bex) it loads the new target, kills the wrong-path instructions in F/D and D/X, and ignores further redirects during a fixed shadow window. Sits between the execute-stage branch control and the imem/F/D latch in the five-stage processor.

---
 rtl/pc_redirect_unit_pkg.sv | 16 +
 rtl/pc_redirect_unit_perf.sv | 29 ++
 rtl/pc_redirect_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the fetch-side PC owner and redirect/flush controller.
// Covers the FSM state encoding, the PC width, the reset PC default and the slots squashed per redirect.
package pc_redirect_unit_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'd0;

  // Each accepted redirect kills the F/D and D/X slots.
  localparam logic [31:0] SQUASH_PER_REDIRECT = 32'd2;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } state_t;

endpackage

// File: rtl/pc_redirect_unit_perf.sv
// redirect_perf_counter: wrapping counters of accepted redirects and squashed pipeline slots.
// The top instantiates it only when PC_REDIRECT_PERF_EN is defined.
module redirect_perf_counter
  import pc_redirect_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] redirect_count,
  output logic [31:0] squash_count
);

  logic [31:0] redirect_count_q;
  logic [31:0] squash_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      redirect_count_q <= '0;
      squash_count_q   <= '0;
    end else if (inc) begin
      redirect_count_q <= redirect_count_q + 32'd1;
      squash_count_q   <= squash_count_q + SQUASH_PER_REDIRECT;
    end
  end

  assign redirect_count = redirect_count_q;
  assign squash_count   = squash_count_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: holds the PC and captures the F/D PC. An accepted redirect squashes F/D and D/X,
// and later redirects are ignored for FLUSH_DEPTH cycles. Optional counters: PC_REDIRECT_PERF_EN.
//
// state  | meaning
// RUN    | redirects accepted
// SHADOW | redirects ignored while the shadow counter runs down to 1
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned     FLUSH_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            stall,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] fd_pc,
  output logic            fd_valid,
  output logic            squash_fd,
  output logic            squash_dx,
`ifdef PC_REDIRECT_PERF_EN
  output logic [31:0]     redirect_count,
  output logic [31:0]     squash_count,
`endif
  output logic            redirect_taken
);

  localparam logic [2:0] SHADOW_LOAD = 3'(FLUSH_DEPTH);

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            accept;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] fd_pc_q;
  logic            fd_valid_q;

  // Reset masks the accept so no squash is signalled while reset is held.
  assign accept = redirect_valid && (state_q == RUN) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (accept) begin
          state_d = SHADOW;
          cnt_d   = SHADOW_LOAD;
        end
      end
      SHADOW: begin
        // Counts every cycle, stalled or not, so the window has a fixed length.
        if (cnt_q <= 3'd1) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Redirect wins over stall; fd_pc keeps its old value on a squash.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      fd_pc_q    <= '0;
      fd_valid_q <= 1'b0;
    end else if (accept) begin
      pc_q       <= redirect_target;
      fd_valid_q <= 1'b0;
    end else if (!stall) begin
      pc_q       <= pc_q + 32'd1;
      fd_pc_q    <= pc_q;
      fd_valid_q <= 1'b1;
    end
  end

  assign imem_addr      = pc_q;
  assign fd_pc          = fd_pc_q;
  assign fd_valid       = fd_valid_q;
  assign squash_fd      = accept;
  assign squash_dx      = accept;
  assign redirect_taken = accept;

`ifdef PC_REDIRECT_PERF_EN
  redirect_perf_counter u_perf (
    .clock          (clock),
    .reset          (reset),
    .inc            (accept),
    .redirect_count (redirect_count),
    .squash_count   (squash_count)
  );
`endif

endmodule
